// File: rtl/branch_pred_pht.sv
// Direction predictor: PHT of saturating counters, indexed bimodally or with gshare.
// Lookup in fetch, prediction registered for decode, training from execute.
module branch_pred_pht #(
  parameter int PHT_LOG2  = 6,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 4,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pcF,
  input  logic                 lookupF,
  input  logic                 stallD,
  input  logic                 flushD,
  output logic                 pred_takenD,
  output logic [PHT_LOG2-1:0]  pred_idxD,
  output logic                 ready,
  input  logic                 upd_valid,
  input  logic [PHT_LOG2-1:0]  upd_idx,
  input  logic                 upd_taken,
  input  logic                 upd_mispred,
  output logic [PERF_BITS-1:0] perf_lookups,
  output logic [PERF_BITS-1:0] perf_mispred
);

  localparam int ENTRIES = 1 << PHT_LOG2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state, state_next;
  logic [PHT_LOG2-1:0]  sweep_ptr;
  logic [PHT_LOG2-1:0]  hist;
  logic [PHT_LOG2-1:0]  idx;
  logic [CTR_BITS-1:0]  ctr_cur, ctr_next;
  logic                 upd_en;
  logic                 unused_pc;

  logic [CTR_BITS-1:0]  pht [ENTRIES];

  assign ready     = (state == RUN);
  assign upd_en    = ready & upd_valid;
  assign idx       = pcF[PHT_LOG2+1:2] ^ hist;
  assign unused_pc = ^{pcF[31:PHT_LOG2+2], pcF[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep_ptr <= sweep_ptr + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (&sweep_ptr) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Non-speculative global history: only resolved branches shift in.
  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr;
      always_ff @(posedge clk) begin
        if (rst)         ghr <= '0;
        else if (upd_en) ghr <= GHR_BITS'({ghr, upd_taken});
      end
      assign hist = PHT_LOG2'(ghr);
    end else begin : g_bimodal
      assign hist = '0;
    end
  endgenerate

  always_comb begin
    ctr_cur  = pht[upd_idx];
    ctr_next = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
    end
  end

  // NOTE: the table has no reset branch; it is initialised by the INIT sweep, one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) pht[sweep_ptr] <= CTR_WNT;
      else if (upd_valid) pht[upd_idx] <= ctr_next;
    end
  end

  // Reads the pre-update counter on a same-entry collision; there is no bypass.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      pred_takenD <= 1'b0;
      pred_idxD   <= '0;
    end else if (!stallD) begin
      pred_takenD <= pht[idx][CTR_BITS-1] & lookupF & ready;
      pred_idxD   <= idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lookups <= '0;
      perf_mispred <= '0;
    end else if (ready) begin
      if (lookupF && !stallD && !flushD && !(&perf_lookups))
        perf_lookups <= perf_lookups + 1'b1;
      if (upd_valid && upd_mispred && !(&perf_mispred))
        perf_mispred <= perf_mispred + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pred_pht.sv
// Self-checking bench: a gshare instance (defaults) and a bimodal instance with 4-bit
// perf counters share one stimulus stream and are compared against a behavioural model.
module tb_branch_pred_pht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        lookupF, stallD, flushD;
  logic        upd_valid, upd_taken, upd_mispred;
  logic [5:0]  upd_idx;

  logic        pred_g, pred_b, ready_g, ready_b;
  logic [5:0]  idx_g, idx_b;
  logic [31:0] pl_g, pm_g;
  logic [3:0]  pl_b, pm_b;

  int checks   = 0;
  int failures = 0;

  // Model state, index 0 = gshare (4 history bits), 1 = bimodal (4-bit perf counters).
  int     m_pht  [2][64];
  int     m_ghr  [2];
  bit     m_run  [2];
  int     m_ptr  [2];
  int     m_pred [2];
  int     m_pidx [2];
  longint m_pl   [2];
  longint m_pm   [2];

  always #5 clk = ~clk;

  branch_pred_pht dut_g (
    .clk(clk), .rst(rst), .pcF(pcF), .lookupF(lookupF), .stallD(stallD), .flushD(flushD),
    .pred_takenD(pred_g), .pred_idxD(idx_g), .ready(ready_g),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .perf_lookups(pl_g), .perf_mispred(pm_g)
  );

  branch_pred_pht #(.PHT_LOG2(6), .CTR_BITS(2), .GHR_BITS(0), .PERF_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .pcF(pcF), .lookupF(lookupF), .stallD(stallD), .flushD(flushD),
    .pred_takenD(pred_b), .pred_idxD(idx_b), .ready(ready_b),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .perf_lookups(pl_b), .perf_mispred(pm_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour, evaluated with the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int     hbits = (k == 0) ? 4 : 0;
      longint pmax  = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
      if (rst) begin
        m_run[k] = 0; m_ptr[k] = 0; m_pred[k] = 0; m_pidx[k] = 0;
        m_ghr[k] = 0; m_pl[k] = 0;  m_pm[k] = 0;
      end else begin
        int l_idx = ((pcF >> 2) % 64) ^ m_ghr[k];
        bit was_run = m_run[k];
        if (flushD) begin
          m_pred[k] = 0; m_pidx[k] = 0;
        end else if (!stallD) begin
          m_pred[k] = (m_pht[k][l_idx] >= 2 && lookupF && was_run) ? 1 : 0;
          m_pidx[k] = l_idx;
        end
        if (was_run) begin
          if (lookupF && !stallD && !flushD && m_pl[k] < pmax) m_pl[k]++;
          if (upd_valid && upd_mispred && m_pm[k] < pmax) m_pm[k]++;
          if (upd_valid) begin
            if (upd_taken) m_pht[k][upd_idx] = (m_pht[k][upd_idx] < 3) ? m_pht[k][upd_idx] + 1 : 3;
            else           m_pht[k][upd_idx] = (m_pht[k][upd_idx] > 0) ? m_pht[k][upd_idx] - 1 : 0;
            if (hbits > 0) m_ghr[k] = (m_ghr[k] * 2 + int'(upd_taken)) % (1 << hbits);
          end
        end else begin
          m_pht[k][m_ptr[k]] = 1;
          if (m_ptr[k] == 63) m_run[k] = 1;
          m_ptr[k] = (m_ptr[k] + 1) % 64;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pred_g",  32'(pred_g),  32'(m_pred[0]));
    check("idx_g",   32'(idx_g),   32'(m_pidx[0]));
    check("ready_g", 32'(ready_g), 32'(m_run[0]));
    check("perfl_g", pl_g,         32'(m_pl[0]));
    check("perfm_g", pm_g,         32'(m_pm[0]));
    check("pred_b",  32'(pred_b),  32'(m_pred[1]));
    check("idx_b",   32'(idx_b),   32'(m_pidx[1]));
    check("ready_b", 32'(ready_b), 32'(m_run[1]));
    check("perfl_b", 32'(pl_b),    32'(m_pl[1]));
    check("perfm_b", 32'(pm_b),    32'(m_pm[1]));
  endtask

  task automatic idle();
    rst = 0; lookupF = 0; stallD = 0; flushD = 0;
    upd_valid = 0; upd_idx = '0; upd_taken = 0; upd_mispred = 0;
  endtask

  task automatic upd(input int i, input bit t, input bit m);
    upd_valid = 1; upd_idx = 6'(i); upd_taken = t; upd_mispred = m;
  endtask

  task automatic reset_and_sweep();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 64; i++) tick();
  endtask

  initial begin
    idle();
    pcF = 32'h0040_0000;

    // Reset sweep: ready exactly on the 64th edge, no predictions while initialising.
    rst = 1; tick();
    check("rst_pred", 32'(pred_b), 32'd0);
    check("rst_idx",  32'(idx_g),  32'd0);
    check("rst_rdy",  32'(ready_g), 32'd0);
    rst = 0; lookupF = 1;
    for (int i = 0; i < 30; i++) begin pcF = $urandom; tick(); end
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 64; i++) begin
      pcF = $urandom;
      tick();
      check("sweep_ready", 32'(ready_b), (i == 63) ? 32'd1 : 32'd0);
      if (i < 63) check("sweep_pred", 32'(pred_g | pred_b), 32'd0);
    end

    // Bimodal training on idx 4, including a same-cycle lookup/update collision.
    pcF = 32'h0040_0010; lookupF = 1;
    tick();
    check("bim_init_pred", 32'(pred_b), 32'd0);
    check("bim_init_idx",  32'(idx_b),  32'd4);
    upd(4, 1, 0); tick();
    check("collide_pred", 32'(pred_b), 32'd0);
    upd_valid = 0; tick();
    check("after_collide", 32'(pred_b), 32'd1);
    upd(4, 1, 0); tick(); tick();
    upd_valid = 0; tick();
    check("sat_hi_pred", 32'(pred_b), 32'd1);
    upd(4, 0, 0); tick();
    upd_valid = 0; tick();
    check("ctr2_pred", 32'(pred_b), 32'd1);
    upd(4, 0, 0); tick();
    upd_valid = 0; tick();
    check("ctr1_pred", 32'(pred_b), 32'd0);

    // Gshare: four taken resolutions fill the history with ones.
    for (int i = 0; i < 4; i++) begin upd(9, 1, 0); tick(); end
    upd_valid = 0; tick();
    check("gshare_idx", 32'(idx_g), 32'h0B);

    // Low saturation on idx 7.
    pcF = 32'h0040_001C;
    for (int i = 0; i < 3; i++) begin upd(7, 0, 0); tick(); end
    upd(7, 1, 0); tick();
    upd_valid = 0; tick();
    check("sat_lo_pred", 32'(pred_b), 32'd0);

    // Stall holds, flush overrides stall.
    pcF = 32'h0040_0024; tick();
    check("pre_stall_pred", 32'(pred_b), 32'd1);
    stallD = 1;
    for (int i = 0; i < 3; i++) begin
      pcF = $urandom; tick();
      check("stall_pred", 32'(pred_b), 32'd1);
      check("stall_idx",  32'(idx_b),  32'd9);
    end
    flushD = 1; tick();
    check("flush_pred", 32'(pred_b), 32'd0);
    check("flush_idx",  32'(idx_b),  32'd0);
    idle();

    // Perf counters from a fresh reset.
    reset_and_sweep();
    lookupF = 1;
    for (int i = 0; i < 20; i++) begin pcF = $urandom; tick(); end
    check("perfl_sat_b", 32'(pl_b), 32'd15);
    check("perfl_g20",   pl_g,      32'd20);
    lookupF = 0;
    for (int i = 0; i < 5; i++) begin upd($urandom_range(0, 63), $urandom_range(0, 1), i < 3); tick(); end
    upd_valid = 0; tick();
    check("perfm_b", 32'(pm_b), 32'd3);
    check("perfm_g", pm_g,      32'd3);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      pcF         = $urandom;
      lookupF     = ($urandom_range(0, 3) != 0);
      stallD      = ($urandom_range(0, 4) == 0);
      flushD      = ($urandom_range(0, 9) == 0);
      upd_valid   = $urandom_range(0, 1);
      upd_idx     = 6'($urandom_range(0, 63));
      upd_taken   = $urandom_range(0, 1);
      upd_mispred = $urandom_range(0, 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
